// File: rtl/shift_add_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_pkg
// Shared definitions for the sequential arithmetic blocks. The FSM encodings
// and state width live here so that future multi-cycle arithmetic blocks can
// reuse the same state numbering.
//   STATE_W   : width of the state register
//   mult_st_t : IDLE=0, RUN=1, DONE=2; encoding 3 is unused and recovers to IDLE
//   cnt_width : width of a step counter that must be able to hold n
// -----------------------------------------------------------------------------
package shift_add_multiplier_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DONE   = 2'd2,
      S_UNUSED = 2'd3
   } mult_st_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_add_multiplier_rca.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
// Plain N-bit ripple-carry adder: {cout, S} = A + B + cin.
//   A, B : N-bit addends
//   cin  : carry into bit 0
//   S    : N-bit sum
//   cout : carry out of bit N-1
// -----------------------------------------------------------------------------
module ripple_carry_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         cin,
   output logic [N-1:0] S,
   output logic         cout
);

   logic [N:0] w_carry;

   assign w_carry[0] = cin;

   // One full adder per bit; the carry chain ripples from bit 0 upward.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_fa
         assign S[gi]           = A[gi] ^ B[gi] ^ w_carry[gi];
         assign w_carry[gi + 1] = (A[gi] & B[gi]) | (w_carry[gi] & (A[gi] ^ B[gi]));
      end
   endgenerate

   assign cout = w_carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned N x N -> 2N multiplier, one shift/add step per clock.
// The running high half (acc) and the multiplicand go through a
// ripple_carry_adder every RUN cycle; the adder's sum and carry-out are
// shifted back into {acc, mq}.
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : a/b valid
//   in_ready  : block can accept operands (IDLE only, low during reset)
//   a, b      : N-bit unsigned multiplicand / multiplier
//   out_valid : product holds a completed result
//   out_ready : downstream accepts product
//   product   : registered 2N-bit result {acc, mq}
// -----------------------------------------------------------------------------
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product
);

   localparam int             CNT_W     = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

   mult_st_t         r_state;
   logic [N-1:0]     r_mcand;
   logic [N-1:0]     r_acc;
   logic [N-1:0]     r_mq;
   logic [CNT_W-1:0] r_cnt;
   // Cleared by reset and set on the first edge after release, so in_ready is
   // held low through reset without a combinational path from rst_n.
   logic             r_rst_done;

   mult_st_t         w_state_next;
   logic [N-1:0]     w_mcand_next;
   logic [N-1:0]     w_acc_next;
   logic [N-1:0]     w_mq_next;
   logic [CNT_W-1:0] w_cnt_next;

   logic [N-1:0]     w_sum;
   logic             w_cout;

   ripple_carry_adder #(.N(N)) u_adder (
      .A    (r_acc),
      .B    (r_mcand),
      .cin  (1'b0),
      .S    (w_sum),
      .cout (w_cout)
   );

   always_comb begin
      w_state_next = r_state;
      w_mcand_next = r_mcand;
      w_acc_next   = r_acc;
      w_mq_next    = r_mq;
      w_cnt_next   = r_cnt;

      case (r_state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               w_mcand_next = a;
               w_mq_next    = b;
               w_acc_next   = '0;
               w_cnt_next   = '0;
               w_state_next = S_RUN;
            end
         end

         S_RUN: begin
            // The consumed multiplier bit leaves mq[0]; the low bit of the new
            // high half drops into mq[N-1]. The adder carry is the only bit
            // that can enter acc[N-1].
            if (r_mq[0]) begin
               {w_acc_next, w_mq_next} = {w_cout, w_sum, r_mq[N-1:1]};
            end else begin
               {w_acc_next, w_mq_next} = {1'b0, r_acc, r_mq[N-1:1]};
            end
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
               w_state_next = S_DONE;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_mcand    <= '0;
         r_acc      <= '0;
         r_mq       <= '0;
         r_cnt      <= '0;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_mcand    <= w_mcand_next;
         r_acc      <= w_acc_next;
         r_mq       <= w_mq_next;
         r_cnt      <= w_cnt_next;
         r_rst_done <= 1'b1;
      end
   end

   assign in_ready  = (r_state == S_IDLE) && r_rst_done;
   assign out_valid = (r_state == S_DONE);
   assign product   = {r_acc, r_mq};

endmodule
